mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port synchronous memory block (enb/rd_wr/addr/data_in/data_out, tri-stated read output, one-cycle registered read).
- Serialises read/write commands from two masters into legal memory access sequences.
- Holds enb/rd_wr through the read-capture cycle so data_out is driven when sampled.
- Returns read data to the correct requester.
Sits between the bus-side masters and the memory instance.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter/sequencer for a single-port synchronous memory with one-cycle registered read.
// Define MEM_ARB_RANGE_CHK_EN to reject (gnt+err, no access) any winning command with addr >= MEM_DEPTH.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_rd_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_rd_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              mem_enb_o,
  output logic              mem_rd_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR       = 2'd1;
  localparam logic [1:0] S_RD_ISSUE = 2'd2;
  localparam logic [1:0] S_RD_CAP   = 2'd3;

`ifdef MEM_ARB_RANGE_CHK_EN
  localparam bit RangeChk = 1'b1;
`else
  localparam bit RangeChk = 1'b0;
`endif
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W+1)'(MEM_DEPTH);

  logic [1:0]        state_q, state_d;
  logic              busy_q;
  logic              last_gnt_q, owner_q;
  logic [1:0]        gnt_q, rvalid_q, err_q;
  logic              enb_q, rd_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;

  logic              any_req, pick_m1, win_rd_wr, win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  always_comb begin
    any_req   = m0_req_i | m1_req_i;
    // On a tie the master that did not win last time goes first.
    pick_m1   = m1_req_i & (~m0_req_i | ~last_gnt_q);
    win_rd_wr = pick_m1 ? m1_rd_wr_i : m0_rd_wr_i;
    win_addr  = pick_m1 ? m1_addr_i  : m0_addr_i;
    win_wdata = pick_m1 ? m1_wdata_i : m0_wdata_i;
    win_oor   = RangeChk && ({1'b0, win_addr} >= DepthLim);
    state_d   = state_q;
    case (state_q)
      S_IDLE:     if (any_req && !win_oor) state_d = win_rd_wr ? S_RD_ISSUE : S_WR;
      S_WR:       state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      enb_q      <= 1'b0;
      rd_wr_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != S_IDLE);
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            last_gnt_q <= pick_m1;
            owner_q    <= pick_m1;
            gnt_q      <= pick_m1 ? 2'b10 : 2'b01;
            if (win_oor) begin
              err_q <= pick_m1 ? 2'b10 : 2'b01;
            end else begin
              enb_q   <= 1'b1;
              rd_wr_q <= win_rd_wr;
              addr_q  <= win_addr;
              wdata_q <= win_wdata;
            end
          end
        end
        S_WR: begin
          enb_q   <= 1'b0;
          rd_wr_q <= 1'b1;
        end
        // enb/rd_wr/addr stayed put through this cycle, so data_out is driven now.
        S_RD_CAP: begin
          enb_q <= 1'b0;
          if (owner_q) begin
            rdata1_q    <= mem_data_out_i;
            rvalid_q[1] <= 1'b1;
          end else begin
            rdata0_q    <= mem_data_out_i;
            rvalid_q[0] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt_o      = gnt_q[0];
  assign m1_gnt_o      = gnt_q[1];
  assign m0_rvalid_o   = rvalid_q[0];
  assign m1_rvalid_o   = rvalid_q[1];
  assign m0_err_o      = err_q[0];
  assign m1_err_o      = err_q[1];
  assign m0_rdata_o    = rdata0_q;
  assign m1_rdata_o    = rdata1_q;
  assign mem_enb_o     = enb_q;
  assign mem_rd_wr_o   = rd_wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_in_o = wdata_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-master command queues, a transaction-level arbitration/timing model
// (accept-to-accept 2 cycles for writes, 3 for reads, rvalid two cycles after gnt) and a behavioural memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 2048;
`ifdef MEM_ARB_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    delay;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    rd = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  wire  [1:0]    gnt, rvalid, err;
  wire  [DW-1:0] rdata0, rdata1;
  wire           mem_enb, mem_rd_wr, busy;
  wire  [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_din, mem_dout;

  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_rdata [2];
  cmd_t          cq [2][$];
  int            grant_log [$];
  int            last_m, enb_cycles;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_rd_wr_i(rd[0]), .m0_addr_i(addr0), .m0_wdata_i(wd0),
    .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata0), .m0_err_o(err[0]),
    .m1_req_i(req[1]), .m1_rd_wr_i(rd[1]), .m1_addr_i(addr1), .m1_wdata_i(wd1),
    .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata1), .m1_err_o(err[1]),
    .mem_enb_o(mem_enb), .mem_rd_wr_o(mem_rd_wr), .mem_addr_o(mem_addr),
    .mem_data_in_o(mem_din), .mem_data_out_i(mem_dout), .busy_o(busy)
  );

  // Single-port memory: registered read, output driven only while enb && rd_wr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
      rd_q <= '0;
    end else if (mem_enb) begin
      if (mem_rd_wr) rd_q <= mem_arr[mem_addr[10:0]];
      else mem_arr[mem_addr[10:0]] <= mem_din;
    end
  end
  assign mem_dout = (mem_enb && mem_rd_wr) ? rd_q : {DW{1'bz}};

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_m = 1;
  endtask

  task automatic present(input int m, input logic on, input cmd_t c);
    if (m == 0) begin req[0] = on; rd[0] = c.rd; addr0 = c.addr; wd0 = c.data; end
    else begin req[1] = on; rd[1] = c.rd; addr1 = c.addr; wd1 = c.data; end
  endtask

  task automatic drive_head(input int m, input int wc);
    if (cq[m].size() > 0 && wc == 0) present(m, 1'b1, cq[m][0]);
    else present(m, 1'b0, '0);
  endtask

  task automatic push_cmd(input int m, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d, input int dly);
    cmd_t c;
    c.rd = r; c.addr = a; c.data = d; c.delay = 8'(dly);
    cq[m].push_back(c);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Plays both queues against the DUT, starting with the DUT idle and at a sample point.
  task automatic run_traffic(input int max_cycles);
    int next_idle, w, t;
    int wait_cnt [2];
    int rv_t [2];
    logic [DW-1:0] rv_d [2];
    logic [1:0] rq, eg, ee, ev;
    logic cur_rd, eb;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    cmd_t c;
    next_idle = 1; cur_rd = 1'b1; cur_addr = '0; cur_data = '0; t = 0;
    grant_log.delete();
    for (int m = 0; m < 2; m++) begin
      rv_t[m] = -1;
      rv_d[m] = '0;
      wait_cnt[m] = (cq[m].size() > 0) ? int'(cq[m][0].delay) : 0;
      drive_head(m, wait_cnt[m]);
    end
    while (1) begin
      t++;
      rq = req;
      @(posedge clk); #1;
      eg = '0; ee = '0; ev = '0;
      if (t == next_idle) begin
        next_idle = t + 1;
        if (rq != 2'b00) begin
          w = (rq == 2'b11) ? (1 - last_m) : (rq[1] ? 1 : 0);
          c = cq[w][0];
          eg[w] = 1'b1;
          last_m = w;
          if (RCHK && int'(c.addr) >= DEPTH) begin
            ee[w] = 1'b1;
          end else begin
            cur_rd = c.rd; cur_addr = c.addr; cur_data = c.data;
            if (c.rd) begin
              next_idle = t + 3;
              rv_t[w] = t + 2;
              rv_d[w] = model_mem[int'(c.addr) % DEPTH];
            end else begin
              next_idle = t + 2;
              model_mem[int'(c.addr) % DEPTH] = c.data;
            end
          end
        end
      end
      for (int m = 0; m < 2; m++) if (rv_t[m] == t) begin ev[m] = 1'b1; exp_rdata[m] = rv_d[m]; end
      eb = (t <= next_idle - 2);
      if (gnt == 2'b01) grant_log.push_back(0);
      if (gnt == 2'b10) grant_log.push_back(1);
      if (mem_enb === 1'b1) enb_cycles++;

      checks++; if (gnt !== eg) begin errors++; $display("FAIL gnt t=%0d got=%b exp=%b", t, gnt, eg); end
      checks++; if (err !== ee) begin errors++; $display("FAIL err t=%0d got=%b exp=%b", t, err, ee); end
      checks++; if (rvalid !== ev) begin errors++; $display("FAIL rvalid t=%0d got=%b exp=%b", t, rvalid, ev); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL busy t=%0d got=%b exp=%b", t, busy, eb); end
      checks++; if (mem_enb !== eb) begin errors++; $display("FAIL mem_enb t=%0d got=%b exp=%b", t, mem_enb, eb); end
      checks++;
      if (mem_rd_wr !== (eb ? cur_rd : 1'b1)) begin
        errors++; $display("FAIL mem_rd_wr t=%0d got=%b exp=%b", t, mem_rd_wr, (eb ? cur_rd : 1'b1));
      end
      if (eb) begin
        checks++;
        if (mem_addr !== cur_addr) begin errors++; $display("FAIL mem_addr t=%0d got=%h exp=%h", t, mem_addr, cur_addr); end
      end
      if (eb && !cur_rd) begin
        checks++;
        if (mem_din !== cur_data) begin errors++; $display("FAIL mem_data_in t=%0d got=%h exp=%h", t, mem_din, cur_data); end
      end
      checks++; if (rdata0 !== exp_rdata[0]) begin errors++; $display("FAIL m0_rdata t=%0d got=%h exp=%h", t, rdata0, exp_rdata[0]); end
      checks++; if (rdata1 !== exp_rdata[1]) begin errors++; $display("FAIL m1_rdata t=%0d got=%h exp=%h", t, rdata1, exp_rdata[1]); end

      for (int m = 0; m < 2; m++) begin
        if (eg[m]) begin
          void'(cq[m].pop_front());
          if (cq[m].size() > 0) wait_cnt[m] = int'(cq[m][0].delay);
        end else if (!req[m] && cq[m].size() > 0 && wait_cnt[m] > 0) begin
          wait_cnt[m]--;
        end
        drive_head(m, wait_cnt[m]);
      end
      if (cq[0].size() == 0 && cq[1].size() == 0 && next_idle == t + 1 && rv_t[0] <= t && rv_t[1] <= t) break;
      if (t >= max_cycles) begin
        checks++; errors++;
        $display("FAIL traffic_timeout t=%0d got=%0d/%0d queued exp=0/0", t, cq[0].size(), cq[1].size());
        cq[0].delete(); cq[1].delete();
        req = '0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", err); end
    checks++; if (rdata0 !== '0 || rdata1 !== '0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
    checks++; if (mem_enb !== 1'b0) begin errors++; $display("FAIL reset_mem_enb got=%b exp=0", mem_enb); end
    checks++; if (mem_rd_wr !== 1'b1) begin errors++; $display("FAIL reset_mem_rd_wr got=%b exp=1", mem_rd_wr); end
    checks++; if (mem_addr !== '0 || mem_din !== '0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    push_cmd(0, 1'b0, 16'h0010, 32'hDEADBEEF, 0);
    push_cmd(0, 1'b1, 16'h0010, 32'h0, 0);
    run_traffic(40);
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata got=%h exp=deadbeef", rdata0); end
    checks++; if (rdata1 !== '0) begin errors++; $display("FAIL basic_m1_rdata got=%h exp=0", rdata1); end
  endtask

  task automatic test_tie();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      push_cmd(0, 1'b0, AW'(k), $urandom, 0);
      push_cmd(1, 1'b0, AW'(k + 8), $urandom, 0);
    end
    run_traffic(60);
    checks++; if (grant_log.size() != 6) begin errors++; $display("FAIL tie_count got=%0d exp=6", grant_log.size()); end
    for (int i = 0; i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] != (i % 2)) begin errors++; $display("FAIL tie_order i=%0d got=m%0d exp=m%0d", i, grant_log[i], i % 2); end
    end
  endtask

  task automatic test_cross();
    enb_cycles = 0;
    push_cmd(1, 1'b0, 16'h07FF, 32'h00AA5500, 0);
    push_cmd(0, 1'b1, 16'h07FF, 32'h0, 1);
    run_traffic(40);
    checks++; if (rdata0 !== 32'h00AA5500) begin errors++; $display("FAIL cross_rdata got=%h exp=00aa5500", rdata0); end
    checks++; if (enb_cycles != 3) begin errors++; $display("FAIL cross_enb_cycles got=%0d exp=3", enb_cycles); end
  endtask

  task automatic test_range();
    enb_cycles = 0;
    push_cmd(0, 1'b1, 16'h0800, 32'h0, 0);
    run_traffic(40);
    checks++;
    if (enb_cycles != (RCHK ? 0 : 2)) begin errors++; $display("FAIL range_enb_cycles got=%0d exp=%0d", enb_cycles, (RCHK ? 0 : 2)); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) push_cmd(0, 1'b1, AW'($urandom_range(0, 31)), 32'h0, 0);
    push_cmd(1, 1'b0, 16'h0020, $urandom, 4);
    run_traffic(80);
  endtask

  task automatic test_reset_mid_read();
    cmd_t c;
    int n;
    c.rd = 1'b1; c.addr = 16'h07FF; c.data = '0; c.delay = '0;
    present(0, 1'b1, c);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (gnt[0] !== 1'b1 && n < 10);
    checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt got=%b exp=1", gnt[0]); end
    present(0, 1'b0, c);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (mem_enb !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_enb got=%b exp=0", mem_enb); end
    checks++; if (mem_rd_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_mem_rd_wr got=%b exp=1", mem_rd_wr); end
    checks++; if (rdata0 !== '0) begin errors++; $display("FAIL rst_mid_rdata got=%h exp=0", rdata0); end
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rst_mid_rvalid got=%b exp=00", rvalid); end
    end
    rst_n = 1'b1;
    model_reset();
    push_cmd(0, 1'b0, 16'h0123, 32'hCAFEF00D, 0);
    push_cmd(0, 1'b1, 16'h0123, 32'h0, 1);
    run_traffic(40);
    checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_mid_after got=%h exp=cafef00d", rdata0); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 8; k++) begin
          push_cmd(m, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)));
        end
      end
      run_traffic(400);
    end
  endtask

  initial begin
    model_reset();
    enb_cycles = 0;
    test_reset();
    test_basic();
    test_tie();
    test_cross();
    test_range();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
